// File: rtl/mmio_timer_pkg.sv
// ----------------------------------------------------------------------------
// mmio_timer_pkg
//   Shared constants for the memory-mapped timer: bus widths, register
//   indices (addr[4:2]), CTRL/STATUS bit positions, the COMPARE reset value
//   and a byte-lane merge helper used by the register write path.
// ----------------------------------------------------------------------------
package mmio_timer_pkg;

  // Bus widths
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned SEL_W   = DATA_W / 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CTRL_W  = 3;
  localparam int unsigned PRESC_W = 16;

  // Register indices (byte offset >> 2)
  localparam logic [IDX_W-1:0] IDX_CTRL     = IDX_W'(0);  // 0x00
  localparam logic [IDX_W-1:0] IDX_COUNT    = IDX_W'(1);  // 0x04
  localparam logic [IDX_W-1:0] IDX_COMPARE  = IDX_W'(2);  // 0x08
  localparam logic [IDX_W-1:0] IDX_STATUS   = IDX_W'(3);  // 0x0C
  localparam logic [IDX_W-1:0] IDX_PRESCALE = IDX_W'(4);  // 0x10

  // CTRL / STATUS bit positions
  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_RELOAD_BIT  = 1;
  localparam int unsigned CTRL_IE_BIT      = 2;
  localparam int unsigned STATUS_MATCH_BIT = 0;

  // Reset value of COMPARE
  localparam logic [DATA_W-1:0] COMPARE_RST = 32'hFFFF_FFFF;

  // Replace the byte lanes of old_val selected by lanes with wr_val.
  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] wr_val,
    input logic [SEL_W-1:0]  lanes
  );
    logic [DATA_W-1:0] r;
    r = old_val;
    for (int b = 0; b < int'(SEL_W); b++) begin
      if (lanes[b]) r[8*b +: 8] = wr_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// ----------------------------------------------------------------------------
// timer_prescaler
//   Divides the clock into a tick pulse for the timer: while en=1, tick is
//   high for one cycle out of every div+1. clr restarts the division.
//   Only present when TIMER_PRESCALE_EN is defined.
//
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   en    in   count enable (timer EN); counter holds when low
//   div   in   division value (period = div+1 cycles)
//   clr   in   restart the internal counter at 0
//   tick  out  one-cycle tick, combinational from counter state
// ----------------------------------------------------------------------------
`ifdef TIMER_PRESCALE_EN
module timer_prescaler
  import mmio_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] div,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  assign tick = en && (cnt_q == div);

  // Next count: clear wins, then hold when disabled, wrap at div.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/mmio_timer.sv
// ----------------------------------------------------------------------------
// mmio_timer
//   32-bit memory-mapped timer with compare match, optional auto-reload and
//   an interrupt output. Register window is 32 bytes at BASE_ADDR:
//     0x00 CTRL     bit0 EN, bit1 RELOAD, bit2 IE
//     0x04 COUNT    free-running counter (r/w)
//     0x08 COMPARE  match value (r/w)
//     0x0C STATUS   bit0 MATCH, write 1 to clear
//     0x10 PRESCALE [15:0] tick divider (only with TIMER_PRESCALE_EN)
//   Build option: define TIMER_PRESCALE_EN to add the PRESCALE register and
//   the timer_prescaler sub-module; otherwise the timer ticks every cycle.
//
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   ce      in   bus access strobe
//   we      in   1 = write, 0 = read
//   addr    in   byte address
//   sel     in   byte-lane enables
//   data_i  in   write data
//   data_o  out  read data, combinational, 0 when not a read hit
//   hit_o   out  access decodes to this block, combinational
//   irq_o   out  MATCH & IE, masked while rst is high
// ----------------------------------------------------------------------------
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              hit_o,
  output logic              irq_o
);

  logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
  logic [DATA_W-1:0] count_q,   count_d;
  logic [DATA_W-1:0] compare_q, compare_d;
  logic              match_q,   match_d;

  logic [IDX_W-1:0]  idx_c;
  logic              wr_c;
  logic              rd_c;
  logic              tick_c;
  logic              match_c;
  logic              addr_unused_c;

  // Address decode: window is 32-byte aligned, word index in addr[4:2].
  assign hit_o         = ce && (addr[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5]);
  assign idx_c         = addr[4:2];
  assign wr_c          = hit_o && we;
  assign rd_c          = hit_o && !we;
  assign addr_unused_c = ^addr[1:0];

`ifdef TIMER_PRESCALE_EN
  logic [PRESC_W-1:0] prescale_q, prescale_d;
  logic               presc_wr_c;

  assign presc_wr_c = wr_c && (idx_c == IDX_PRESCALE);

  // PRESCALE register: only the low two lanes exist.
  always_comb begin
    prescale_d = prescale_q;
    if (presc_wr_c) begin
      for (int b = 0; b < 2; b++) begin
        if (sel[b]) prescale_d[8*b +: 8] = data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) prescale_q <= '0;
    else     prescale_q <= prescale_d;
  end

  // Any PRESCALE write restarts the division so the new period starts cleanly.
  timer_prescaler u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (ctrl_q[CTRL_EN_BIT]),
    .div  (prescale_q),
    .clr  (presc_wr_c),
    .tick (tick_c)
  );
`else
  assign tick_c = ctrl_q[CTRL_EN_BIT];
`endif

  // A match only counts on a tick; tick is already gated by EN.
  assign match_c = tick_c && (count_q == compare_q);

  // Register next-state: timer action first, bus write overrides lane-wise.
  always_comb begin
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    compare_d = compare_q;
    match_d   = match_q;

    if (match_c && ctrl_q[CTRL_RELOAD_BIT]) begin
      count_d = '0;
    end else if (tick_c) begin
      count_d = count_q + DATA_W'(1);
    end

    if (wr_c) begin
      case (idx_c)
        IDX_CTRL: begin
          if (sel[0]) ctrl_d = data_i[CTRL_W-1:0];
        end
        IDX_COUNT: begin
          count_d = lane_merge(count_d, data_i, sel);
        end
        IDX_COMPARE: begin
          compare_d = lane_merge(compare_q, data_i, sel);
        end
        IDX_STATUS: begin
          if (sel[0] && data_i[STATUS_MATCH_BIT]) match_d = 1'b0;
        end
        default: begin
        end
      endcase
    end

    // A new match beats a same-cycle clear.
    if (match_c) match_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      count_q   <= '0;
      compare_q <= COMPARE_RST;
      match_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
    end
  end

  // Zero-latency read mux.
  always_comb begin
    data_o = '0;
    if (rd_c) begin
      case (idx_c)
        IDX_CTRL:    data_o = {(DATA_W-CTRL_W)'(0), ctrl_q};
        IDX_COUNT:   data_o = count_q;
        IDX_COMPARE: data_o = compare_q;
        IDX_STATUS:  data_o = {(DATA_W-1)'(0), match_q};
`ifdef TIMER_PRESCALE_EN
        IDX_PRESCALE: data_o = {(DATA_W-PRESC_W)'(0), prescale_q};
`endif
        default:     data_o = '0;
      endcase
    end
  end

  assign irq_o = match_q && ctrl_q[CTRL_IE_BIT] && !rst;

endmodule
